usb_sts_ctrl: RTL and testbench
===============================

USB_STS_CTRL -- requirements
Module: usb_sts_ctrl

Interface
REQ-001 SHALL have ports: clk input 1 system clock; rst_n input 1 reset, asynchronous, active-low.
REQ-002 SHALL have ports: cmd_wr input 1 USBCMD write strobe; cmd_wdata input 2 [0]=RS, [1]=HCRESET.
REQ-003 SHALL have ports: sts_wr input 1 USBSTS write strobe; sts_wdata input 5 write-1-to-clear mask for status bits [4:0].
REQ-004 SHALL have ports: intr_wr input 1 USBINTR write strobe; intr_wdata input 4 enables [0]=timeout/CRC, [1]=resume, [2]=IOC, [3]=short packet.
REQ-005 SHALL have ports, all 1-bit single-cycle pulse inputs: ev_ioc, ev_short, ev_usberr, ev_resume, ev_hse (host system error), ev_hcpe (process error from error logic), frame_end (frame boundary).
REQ-006 SHALL have ports: rs output 1 Run/Stop; hc_halted output 1; sts_rdata output 6 USBSTS image; intr_rdata output 4; irq output 1; hcreset_busy output 1.

Function
REQ-007 SHALL implement FSM states HALTED, RUNNING, STOPPING; rs=1 in RUNNING only; hc_halted=1 in HALTED only.
REQ-008 SHALL move HALTED->RUNNING on the clock edge sampling cmd_wr with cmd_wdata[0]=1; rs=1, hc_halted=0 from the next cycle.
REQ-009 SHALL move RUNNING->STOPPING on cmd_wr with cmd_wdata[0]=0; rs=0 next cycle; hc_halted remains 0.
REQ-010 SHALL move STOPPING->HALTED on frame_end; hc_halted=1 next cycle.
REQ-011 SHALL move STOPPING->RUNNING on cmd_wr with cmd_wdata[0]=1, cancelling the stop.
REQ-012 SHALL move RUNNING or STOPPING directly to HALTED when ev_hse or ev_hcpe is 1, regardless of frame_end or cmd_wr in the same cycle.
REQ-013 SHALL ignore cmd_wr with cmd_wdata[0]=0 in HALTED, and cmd_wr with cmd_wdata[0]=1 in RUNNING.
REQ-014 SHALL hold status bits: sts[0] USBINT, set by ev_ioc or ev_short; sts[1] USB error, set by ev_usberr; sts[2] resume, set by ev_resume; sts[3] HSE, set by ev_hse; sts[4] HCPE, set by ev_hcpe.
REQ-015 SHALL set status bits in every FSM state.
REQ-016 SHALL clear sts[n] on sts_wr when sts_wdata[n]=1.
REQ-017 SHALL give set priority over clear when an event and a W1C hit the same bit in the same cycle.
REQ-018 SHALL drive sts_rdata[4:0]=sts[4:0] and sts_rdata[5]=hc_halted; sts_rdata[5] is read-only and unaffected by writes.
REQ-019 SHALL latch intr_wdata into the enable register on intr_wr; intr_rdata reflects the enable register.
REQ-020 SHALL register irq = (sts[0]&(ie[2]|ie[3])) | (sts[1]&ie[0]) | (sts[2]&ie[1]) | sts[3] | sts[4]; irq lags status by exactly 1 cycle.
REQ-021 SHALL start on cmd_wr with cmd_wdata[1]=1 a 3-bit counter loaded with 4; hcreset_busy=1 while counter is nonzero; counter decrements by 1 per cycle.
REQ-022 SHALL, while hcreset_busy=1, force the FSM to HALTED, clear sts, enables and irq, and ignore all write strobes and events.
REQ-023 SHALL give HCRESET priority over RS when cmd_wdata=2'b11; the RS bit is discarded.
REQ-024 SHALL have a counter that does not wrap: it holds at 0 once expired.

Reset
REQ-025 SHALL, on rst_n=0, asynchronously set: FSM=HALTED, rs=0, hc_halted=1, sts=0, enables=0, irq=0, counter=0, hcreset_busy=0; sts_rdata=6'b100000.
REQ-026 SHALL, if reset is asserted mid-STOPPING or mid-HCRESET, abandon the operation fully with no residual state after release.

Verification
REQ-027 SHALL verify start/stop: cmd_wr cmd_wdata=01 -> rs=1, hc_halted=0 next cycle; cmd_wr 00 -> rs=0, hc_halted=0; frame_end -> hc_halted=1, sts_rdata[5]=1.
REQ-028 SHALL verify error halt: RUNNING, ev_hcpe plus cmd_wr 01 in the same cycle -> HALTED next cycle, sts_rdata=6'b110000, irq=1 one cycle later.
REQ-029 SHALL verify W1C race: sts[0]=1, ev_ioc and sts_wr sts_wdata=00001 in the same cycle -> sts[0] stays 1; next sts_wr 00001 alone -> sts[0]=0, irq=0 one cycle later.
REQ-030 SHALL verify masking: ie=0000, ev_usberr -> sts[1]=1, irq=0; intr_wr 0001 -> irq=1 on the cycle after the enable latches.
REQ-031 SHALL verify HCRESET: RUNNING with sts=5'h1F, cmd_wr 11 -> hcreset_busy=1 for exactly 4 cycles, sts=0, hc_halted=1, events ignored; first cmd_wr 01 after busy drops -> RUNNING.
REQ-032 SHALL verify reset: rst_n low during STOPPING -> outputs at REQ-025 values immediately; after release, frame_end has no effect.

Source files
------------

// File: rtl/usb_sts_if.sv
// Register-access and event bundle between a host-controller front end and usb_sts_ctrl.
// The master drives strobes and events. The slave returns the run state, status and interrupt.
interface usb_sts_if;
    logic       cmd_wr;
    logic [1:0] cmd_wdata;
    logic       sts_wr;
    logic [4:0] sts_wdata;
    logic       intr_wr;
    logic [3:0] intr_wdata;
    logic       ev_ioc;
    logic       ev_short;
    logic       ev_usberr;
    logic       ev_resume;
    logic       ev_hse;
    logic       ev_hcpe;
    logic       frame_end;
    logic       rs;
    logic       hc_halted;
    logic [5:0] sts_rdata;
    logic [3:0] intr_rdata;
    logic       irq;
    logic       hcreset_busy;

    modport master (
        output cmd_wr, cmd_wdata, sts_wr, sts_wdata, intr_wr, intr_wdata,
        output ev_ioc, ev_short, ev_usberr, ev_resume, ev_hse, ev_hcpe, frame_end,
        input  rs, hc_halted, sts_rdata, intr_rdata, irq, hcreset_busy
    );

    modport slave (
        input  cmd_wr, cmd_wdata, sts_wr, sts_wdata, intr_wr, intr_wdata,
        input  ev_ioc, ev_short, ev_usberr, ev_resume, ev_hse, ev_hcpe, frame_end,
        output rs, hc_halted, sts_rdata, intr_rdata, irq, hcreset_busy
    );
endinterface

// File: rtl/usb_sts_ctrl.sv
// USB host-controller run/stop state machine with W1C status, interrupt enables and HCRESET.
// The outputs are registered. HCRESET holds the controller halted and cleared for four cycles.
module usb_sts_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    usb_sts_if.slave   bus
);

    typedef enum logic [1:0] {
        HALTED   = 2'd0,
        RUNNING  = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic       rs_r;
    logic       hc_halted_r;
    logic [4:0] sts_r;
    logic [4:0] sts_s;
    logic [3:0] ie_r;
    logic [3:0] ie_s;
    logic       irq_r;
    logic       irq_s;
    logic [2:0] cnt_r;
    logic [2:0] cnt_s;
    logic       busy_r;

    logic       hc_start_s;
    logic       block_s;
    logic       err_s;
    logic       run_req_s;
    logic       stop_req_s;
    logic [4:0] set_s;
    logic [4:0] clr_s;

    // USBINT qualifies on either IOC or short-packet enable; HSE and HCPE cannot be masked
    function automatic logic irq_eval(input logic [4:0] sts, input logic [3:0] ie);
        return (sts[0] & (ie[2] | ie[3])) | (sts[1] & ie[0]) | (sts[2] & ie[1])
             | sts[3] | sts[4];
    endfunction

    // Request decode; an HCRESET write or a running HCRESET blocks every other update
    always_comb begin
        hc_start_s = bus.cmd_wr & bus.cmd_wdata[1] & ~busy_r;
        block_s    = busy_r | hc_start_s;
        err_s      = bus.ev_hse | bus.ev_hcpe;
        run_req_s  = bus.cmd_wr & bus.cmd_wdata[0];
        stop_req_s = bus.cmd_wr & ~bus.cmd_wdata[0];
        set_s      = {bus.ev_hcpe, bus.ev_hse, bus.ev_resume, bus.ev_usberr,
                      bus.ev_ioc | bus.ev_short};
        clr_s      = bus.sts_wr ? bus.sts_wdata : 5'd0;
    end

    // Next-state logic for the run/stop FSM
    always_comb begin
        state_s = state_r;
        if (block_s) begin
            state_s = HALTED;
        end else begin
            case (state_r)
                HALTED: begin
                    if (run_req_s) state_s = RUNNING;
                    else           state_s = HALTED;
                end
                RUNNING: begin
                    if (err_s)           state_s = HALTED;
                    else if (stop_req_s) state_s = STOPPING;
                    else                 state_s = RUNNING;
                end
                STOPPING: begin
                    if (err_s)              state_s = HALTED;
                    else if (run_req_s)     state_s = RUNNING;
                    else if (bus.frame_end) state_s = HALTED;
                    else                    state_s = STOPPING;
                end
                default: state_s = HALTED;
            endcase
        end
    end

    // Status, enable, interrupt and HCRESET counter next values; a new event wins over a W1C clear
    always_comb begin
        sts_s = sts_r;
        ie_s  = ie_r;
        irq_s = irq_r;
        if (block_s) begin
            sts_s = 5'd0;
            ie_s  = 4'd0;
            irq_s = 1'b0;
        end else begin
            sts_s = (sts_r & ~clr_s) | set_s;
            if (bus.intr_wr) ie_s = bus.intr_wdata;
            else             ie_s = ie_r;
            irq_s = irq_eval(sts_r, ie_r);
        end

        cnt_s = cnt_r;
        if (hc_start_s)          cnt_s = 3'd4;
        else if (cnt_r != 3'd0)  cnt_s = cnt_r - 3'd1;
        else                     cnt_s = 3'd0;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= HALTED;
            rs_r        <= 1'b0;
            hc_halted_r <= 1'b1;
            sts_r       <= 5'd0;
            ie_r        <= 4'd0;
            irq_r       <= 1'b0;
            cnt_r       <= 3'd0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            rs_r        <= (state_s == RUNNING);
            hc_halted_r <= (state_s == HALTED);
            sts_r       <= sts_s;
            ie_r        <= ie_s;
            irq_r       <= irq_s;
            cnt_r       <= cnt_s;
            busy_r      <= (cnt_s != 3'd0);
        end
    end

    assign bus.rs           = rs_r;
    assign bus.hc_halted    = hc_halted_r;
    assign bus.sts_rdata    = {hc_halted_r, sts_r};
    assign bus.intr_rdata   = ie_r;
    assign bus.irq          = irq_r;
    assign bus.hcreset_busy = busy_r;

endmodule

// File: tb/tb_usb_sts_ctrl.sv
// Directed self-checking bench for usb_sts_ctrl, with hand-computed expected values.
// Inputs change 1 time unit after a rising edge, and outputs are sampled there as well.
module tb_usb_sts_ctrl;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    usb_sts_if bus ();

    usb_sts_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.cmd_wr     = 1'b0;
        bus.cmd_wdata  = 2'd0;
        bus.sts_wr     = 1'b0;
        bus.sts_wdata  = 5'd0;
        bus.intr_wr    = 1'b0;
        bus.intr_wdata = 4'd0;
        bus.ev_ioc     = 1'b0;
        bus.ev_short   = 1'b0;
        bus.ev_usberr  = 1'b0;
        bus.ev_resume  = 1'b0;
        bus.ev_hse     = 1'b0;
        bus.ev_hcpe    = 1'b0;
        bus.frame_end  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic cmd(input logic [1:0] d);
        bus.cmd_wr    = 1'b1;
        bus.cmd_wdata = d;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        idle_inputs();
        rst_n = 1'b0;
        #12;
        chk("rst_rs", {7'd0, bus.rs}, 8'd0);
        chk("rst_halted", {7'd0, bus.hc_halted}, 8'd1);
        chk("rst_sts", {2'd0, bus.sts_rdata}, 8'h20);
        chk("rst_intr", {4'd0, bus.intr_rdata}, 8'h0);
        chk("rst_irq", {7'd0, bus.irq}, 8'd0);
        chk("rst_busy", {7'd0, bus.hcreset_busy}, 8'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // A stop command in HALTED is ignored
        cmd(2'b00); tick();
        chk("halt_ign_stop", {7'd0, bus.hc_halted}, 8'd1);

        // Start/stop sequence
        cmd(2'b01); tick();
        chk("start_rs", {7'd0, bus.rs}, 8'd1);
        chk("start_halted", {7'd0, bus.hc_halted}, 8'd0);
        cmd(2'b01); tick();
        chk("run_ign_start", {7'd0, bus.rs}, 8'd1);
        cmd(2'b00); tick();
        chk("stop_rs", {7'd0, bus.rs}, 8'd0);
        chk("stop_halted", {7'd0, bus.hc_halted}, 8'd0);
        tick();
        chk("stopping_hold", {7'd0, bus.hc_halted}, 8'd0);
        bus.frame_end = 1'b1; tick();
        chk("frame_halted", {7'd0, bus.hc_halted}, 8'd1);
        chk("frame_sts5", {2'd0, bus.sts_rdata}, 8'h20);

        // Cancel a pending stop
        cmd(2'b01); tick();
        cmd(2'b00); tick();
        cmd(2'b01); tick();
        chk("cancel_rs", {7'd0, bus.rs}, 8'd1);
        chk("cancel_halted", {7'd0, bus.hc_halted}, 8'd0);

        // A process error wins over a simultaneous start command
        bus.ev_hcpe = 1'b1; cmd(2'b01); tick();
        chk("hcpe_rs", {7'd0, bus.rs}, 8'd0);
        chk("hcpe_sts", {2'd0, bus.sts_rdata}, 8'h30);
        chk("hcpe_irq_lag", {7'd0, bus.irq}, 8'd0);
        tick();
        chk("hcpe_irq", {7'd0, bus.irq}, 8'd1);
        bus.sts_wr = 1'b1; bus.sts_wdata = 5'b10000; tick();
        chk("hcpe_clr", {2'd0, bus.sts_rdata}, 8'h20);
        chk("hcpe_clr_irq_lag", {7'd0, bus.irq}, 8'd1);
        tick();
        chk("hcpe_clr_irq", {7'd0, bus.irq}, 8'd0);

        // W1C race: setting the bit wins over clearing it
        bus.intr_wr = 1'b1; bus.intr_wdata = 4'b0100; tick();
        chk("ie_ioc", {4'd0, bus.intr_rdata}, 8'h4);
        bus.ev_ioc = 1'b1; tick();
        chk("ioc_set", {2'd0, bus.sts_rdata}, 8'h21);
        tick();
        chk("ioc_irq", {7'd0, bus.irq}, 8'd1);
        bus.ev_ioc = 1'b1; bus.sts_wr = 1'b1; bus.sts_wdata = 5'b00001; tick();
        chk("race_set_wins", {2'd0, bus.sts_rdata}, 8'h21);
        bus.sts_wr = 1'b1; bus.sts_wdata = 5'b00001; tick();
        chk("w1c_clear", {2'd0, bus.sts_rdata}, 8'h20);
        tick();
        chk("w1c_irq", {7'd0, bus.irq}, 8'd0);

        // The short-packet enable also qualifies USBINT
        bus.intr_wr = 1'b1; bus.intr_wdata = 4'b1000; tick();
        bus.ev_short = 1'b1; tick();
        chk("short_set", {2'd0, bus.sts_rdata}, 8'h21);
        tick();
        chk("short_irq", {7'd0, bus.irq}, 8'd1);
        bus.sts_wr = 1'b1; bus.sts_wdata = 5'b00001; tick();

        // Masking: the error bit is latched but the irq waits for its enable
        bus.intr_wr = 1'b1; bus.intr_wdata = 4'b0000; tick();
        bus.ev_usberr = 1'b1; tick();
        chk("usberr_set", {2'd0, bus.sts_rdata}, 8'h22);
        tick();
        chk("usberr_masked", {7'd0, bus.irq}, 8'd0);
        bus.intr_wr = 1'b1; bus.intr_wdata = 4'b0001; tick();
        chk("ie_err", {4'd0, bus.intr_rdata}, 8'h1);
        chk("ie_err_irq_lag", {7'd0, bus.irq}, 8'd0);
        tick();
        chk("ie_err_irq", {7'd0, bus.irq}, 8'd1);
        bus.sts_wr = 1'b1; bus.sts_wdata = 5'b11111; tick();
        tick();

        // HCRESET from RUNNING with every status bit set
        bus.ev_ioc = 1'b1; bus.ev_usberr = 1'b1; bus.ev_resume = 1'b1;
        bus.ev_hse = 1'b1; bus.ev_hcpe = 1'b1; tick();
        chk("all_sts", {2'd0, bus.sts_rdata}, 8'h3F);
        cmd(2'b01); tick();
        chk("run_sts1f", {2'd0, bus.sts_rdata}, 8'h1F);
        chk("run_rs", {7'd0, bus.rs}, 8'd1);
        cmd(2'b11); tick();
        chk("hcr_busy1", {7'd0, bus.hcreset_busy}, 8'd1);
        chk("hcr_sts", {2'd0, bus.sts_rdata}, 8'h20);
        chk("hcr_rs", {7'd0, bus.rs}, 8'd0);
        chk("hcr_intr", {4'd0, bus.intr_rdata}, 8'h0);
        bus.ev_ioc = 1'b1; bus.ev_hse = 1'b1; cmd(2'b01);
        bus.intr_wr = 1'b1; bus.intr_wdata = 4'hF; tick();
        chk("hcr_busy2", {7'd0, bus.hcreset_busy}, 8'd1);
        chk("hcr_ign_ev", {2'd0, bus.sts_rdata}, 8'h20);
        chk("hcr_ign_cmd", {7'd0, bus.rs}, 8'd0);
        chk("hcr_ign_ie", {4'd0, bus.intr_rdata}, 8'h0);
        chk("hcr_irq", {7'd0, bus.irq}, 8'd0);
        tick();
        chk("hcr_busy3", {7'd0, bus.hcreset_busy}, 8'd1);
        tick();
        chk("hcr_busy4", {7'd0, bus.hcreset_busy}, 8'd1);
        tick();
        chk("hcr_done", {7'd0, bus.hcreset_busy}, 8'd0);
        tick();
        chk("hcr_no_wrap", {7'd0, bus.hcreset_busy}, 8'd0);
        cmd(2'b01); tick();
        chk("hcr_restart", {7'd0, bus.rs}, 8'd1);

        // Asynchronous reset in the middle of STOPPING
        cmd(2'b00); bus.ev_usberr = 1'b1; tick();
        chk("pre_rst_sts", {2'd0, bus.sts_rdata}, 8'h02);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rs", {7'd0, bus.rs}, 8'd0);
        chk("arst_halted", {7'd0, bus.hc_halted}, 8'd1);
        chk("arst_sts", {2'd0, bus.sts_rdata}, 8'h20);
        tick();
        rst_n = 1'b1;
        bus.frame_end = 1'b1; tick();
        chk("post_rst_frame", {7'd0, bus.hc_halted}, 8'd1);
        chk("post_rst_rs", {7'd0, bus.rs}, 8'd0);

        // Asynchronous reset in the middle of HCRESET
        cmd(2'b11); tick();
        chk("hcr2_busy", {7'd0, bus.hcreset_busy}, 8'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {7'd0, bus.hcreset_busy}, 8'd0);
        tick();
        rst_n = 1'b1;
        tick();
        cmd(2'b01); tick();
        chk("post_hcr_rst_run", {7'd0, bus.rs}, 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
